// File: rtl/reorder_buffer.sv
// In-order retirement buffer: allocates tags at the tail, accepts out-of-order
// writebacks, and retires one completed entry per cycle from the head.
module reorder_buffer #(
   parameter int                  WORD_SIZE = 32,
   parameter int                  RB_SIZE   = 8,
   parameter int                  RB_INDEX  = 4,
   parameter int                  REG_INDEX = 5,
   parameter logic [RB_INDEX-1:0] READY     = '1
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         alloc_req,
   input  logic [REG_INDEX-1:0]         alloc_reg,
   output logic                         alloc_ack,
   output logic [RB_INDEX-1:0]          alloc_index,
   output logic                         full,
   input  logic                         wb_valid,
   input  logic [RB_INDEX-1:0]          wb_index,
   input  logic [WORD_SIZE-1:0]         wb_data,
   input  logic                         flush,
   output logic [WORD_SIZE*RB_SIZE-1:0] CDB_data_data,
   output logic [RB_SIZE-1:0]           CDB_data_valid,
   output logic                         commit_valid,
   output logic [REG_INDEX-1:0]         commit_reg,
   output logic [WORD_SIZE-1:0]         commit_data,
   output logic [RB_INDEX-1:0]          commit_index,
   output logic [RB_INDEX-1:0]          count
);

   localparam int                  PTR_W    = (RB_SIZE > 1) ? $clog2(RB_SIZE) : 1;
   localparam logic [RB_INDEX-1:0] LAST_TAG = RB_INDEX'(RB_SIZE - 1);
   localparam logic [RB_INDEX-1:0] SIZE_TAG = RB_INDEX'(RB_SIZE);

   logic [RB_SIZE-1:0]   busy;
   logic [RB_SIZE-1:0]   done;
   logic [REG_INDEX-1:0] dest  [RB_SIZE];
   logic [WORD_SIZE-1:0] value [RB_SIZE];
   logic [RB_INDEX-1:0]  head;
   logic [RB_INDEX-1:0]  tail;

   logic [PTR_W-1:0]     head_ptr;
   logic [PTR_W-1:0]     tail_ptr;
   logic [PTR_W-1:0]     wb_ptr;
   logic                 commit_fire;
   logic                 wb_hit;
   logic [RB_INDEX-1:0]  head_next;
   logic [RB_INDEX-1:0]  tail_next;

   function automatic logic [RB_INDEX-1:0] wrap_inc(input logic [RB_INDEX-1:0] p);
      return (p == LAST_TAG) ? '0 : p + 1'b1;
   endfunction

   always_comb begin
      head_ptr    = head[PTR_W-1:0];
      tail_ptr    = tail[PTR_W-1:0];
      wb_ptr      = wb_index[PTR_W-1:0];
      head_next   = wrap_inc(head);
      tail_next   = wrap_inc(tail);
      full        = (count == SIZE_TAG);
      alloc_ack   = reset & alloc_req & ~full & ~flush;
      alloc_index = tail;
      // Commit looks only at registered done, so a writeback to the head
      // retires no earlier than the following edge.
      commit_fire = busy[head_ptr] & done[head_ptr];
      // Out-of-range and reserved tags are dropped before the entry lookup.
      wb_hit      = wb_valid & (wb_index < SIZE_TAG) & (wb_index != READY)
                  & busy[wb_ptr] & ~done[wb_ptr];
   end

   always_comb begin
      CDB_data_data  = '0;
      CDB_data_valid = busy & done;
      for (int i = 0; i < RB_SIZE; i++) begin
         CDB_data_data[i*WORD_SIZE +: WORD_SIZE] = value[i];
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         busy         <= '0;
         done         <= '0;
         for (int i = 0; i < RB_SIZE; i++) begin
            dest[i]  <= '0;
            value[i] <= '0;
         end
         head         <= '0;
         tail         <= '0;
         count        <= '0;
         commit_valid <= 1'b0;
         commit_reg   <= '0;
         commit_data  <= '0;
         commit_index <= '0;
      end else if (flush) begin
         busy         <= '0;
         done         <= '0;
         head         <= '0;
         tail         <= '0;
         count        <= '0;
         commit_valid <= 1'b0;
      end else begin
         commit_valid <= commit_fire;
         if (commit_fire) begin
            busy[head_ptr] <= 1'b0;
            done[head_ptr] <= 1'b0;
            commit_reg     <= dest[head_ptr];
            commit_data    <= value[head_ptr];
            commit_index   <= head;
            head           <= head_next;
         end
         // wb_hit needs a busy, not-done entry, so it never targets the
         // entry being committed or the free slot being allocated.
         if (wb_hit) begin
            value[wb_ptr] <= wb_data;
            done[wb_ptr]  <= 1'b1;
         end
         if (alloc_ack) begin
            busy[tail_ptr] <= 1'b1;
            done[tail_ptr] <= 1'b0;
            dest[tail_ptr] <= alloc_reg;
            tail           <= tail_next;
         end
         count <= count + RB_INDEX'(alloc_ack) - RB_INDEX'(commit_fire);
      end
   end

endmodule

// File: doc/reorder_buffer.md
REORDER_BUFFER -- requirements
Module: reorder_buffer

Interface
REQ-001 Parameters SHALL be: WORD_SIZE, default 32, datapath width; RB_SIZE, default 8, number of entries; RB_INDEX, default 4, tag width; REG_INDEX, default 5, architectural register index width; READY, default all-ones in RB_INDEX bits, reserved "no tag" value, never allocated.
REQ-002 Ports SHALL be:
clk  input  1  single clock, rising edge
reset  input  1  asynchronous, active-low
alloc_req  input  1  issue stage requests an entry
alloc_reg  input  REG_INDEX  destination register of the issuing instruction
alloc_ack  output  1  combinational; request accepted this cycle
alloc_index  output  RB_INDEX  combinational; tag granted (current tail)
full  output  1  combinational; count == RB_SIZE
wb_valid  input  1  functional unit result strobe
wb_index  input  RB_INDEX  tag of the result
wb_data  input  WORD_SIZE  result value
flush  input  1  synchronous squash of all entries
CDB_data_data  output  WORD_SIZE*RB_SIZE  entry i value at bits [i*WORD_SIZE +: WORD_SIZE]
CDB_data_valid  output  RB_SIZE  bit i = entry i busy and done
commit_valid  output  1  registered; one-cycle retire pulse
commit_reg  output  REG_INDEX  registered; retired destination register
commit_data  output  WORD_SIZE  registered; retired value
commit_index  output  RB_INDEX  registered; retired tag
count  output  RB_INDEX  registered; occupied entries, 0..RB_SIZE

Function
REQ-003 Each entry SHALL hold busy, done, dest reg, and value; head and tail pointers SHALL each wrap from RB_SIZE-1 to 0.
REQ-004 alloc_ack SHALL equal alloc_req AND NOT full AND NOT flush; alloc_index SHALL equal tail at all times.
REQ-005 On a clock edge with alloc_ack high: entry[tail] SHALL get busy=1, done=0, dest=alloc_reg; tail SHALL advance by one.
REQ-006 On wb_valid with entry[wb_index] busy and not done: value SHALL be set to wb_data and done to 1 at the edge; wb to a non-busy entry, to an already-done entry, or with wb_index >= RB_SIZE SHALL be ignored.
REQ-007 CDB_data_valid and CDB_data_data SHALL reflect register state with one-cycle latency from the writeback edge; data bits of non-valid entries are don't-care.
REQ-008 Commit SHALL fire at an edge when entry[head] has busy=1 and done=1 sampled before that edge: the entry SHALL clear busy/done, head SHALL advance, and commit_valid/reg/data/index SHALL present that entry for exactly the following cycle.
REQ-009 At most one commit per cycle; commit SHALL be strictly in allocation order; a done entry behind a not-done head SHALL wait.
REQ-010 Writeback to the head entry and commit SHALL NOT occur in the same edge; the earliest commit is the edge after the done edge.
REQ-011 count SHALL update as count + alloc_ack - commit; simultaneous alloc and commit when full=1 SHALL NOT occur (alloc refused), and when count=RB_SIZE-1 both SHALL succeed with count unchanged.
REQ-012 flush SHALL take priority over alloc, writeback, and commit in the same edge: all busy/done cleared, head=tail=0, count=0, commit_valid=0.

Reset
REQ-013 While reset is low, and asynchronously on its falling edge: all entries SHALL have busy=0 and done=0; head=tail=0; count=0; CDB_data_valid=0; CDB_data_data=0; commit_valid=0; commit_reg=0; commit_data=0; commit_index=0.
REQ-014 alloc_ack SHALL be 0 while reset is low; operation SHALL resume on the first rising clk edge after reset goes high.
REQ-015 Reset asserted mid-operation SHALL discard all in-flight entries with no commit pulse.

Verification
REQ-016 Allocate 3 entries (regs 1,2,3) -> alloc_index 0,1,2; count=3; CDB_data_valid=8'h00.
REQ-017 Writeback tag 1=0xAA, then tag 0=0x55 -> CDB_data_valid 8'h02, then 8'h03; commit tag 0 (reg 1, 0x55) on the edge after tag 0 done, tag 1 (reg 2, 0xAA) the next cycle; tag 2 still held.
REQ-018 Fill 8 entries -> full=1; a 9th alloc_req -> alloc_ack=0; commit one entry while requesting alloc -> alloc accepted the next cycle with alloc_index=0 after wrap, tail wraps 7 -> 0.
REQ-019 count=7 with head done, alloc_req in the same cycle -> both happen, count stays 7, full=0.
REQ-020 Writeback to a free tag 5, and a duplicate writeback to a done tag -> value and valid unchanged.
REQ-021 flush with 4 busy entries and a simultaneous alloc_req/wb -> count=0, CDB_data_valid=0, alloc_index=0, no commit_valid; repeat with reset low mid-stream -> all outputs zero immediately.
